uart_rx_ctrl: RTL



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync.sv | 15 +
 rtl/uart_rx_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive state encoding and baud timer reload constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int HALF_BIT = 8;
  localparam int FULL_BIT = 16;
  localparam int DEF_DATA_BITS = 8;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: STAGES-deep synchroniser for an idle-high pin, resets to 1
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge arst)
    if (arst) ff <= '1;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving the baud timer and a valid/ready frame output
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 rx_in,
  input  logic                 baud_tick,
  output logic                 baud_rst,
  output logic                 baud_full,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS + 1);
  rx_state_t state;
  logic rx_s, rx_prev, perr_q, ferr_q, commit;
  logic [CW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .arst(arst), .d(rx_in), .q(rx_s));
  assign baud_rst = state == IDLE;
  assign baud_full = state != IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      rx_prev <= 1'b1;
      bit_cnt <= '0;
      sh <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      commit <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      commit <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: if (rx_prev && !rx_s) state <= START;
        START: if (baud_tick) begin
          state <= rx_s ? IDLE : DATA;
          bit_cnt <= '0;
          perr_q <= 1'b0;
        end
        DATA: if (baud_tick) begin
          sh <= {rx_s, sh[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(DATA_BITS - 1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: if (baud_tick) begin
          perr_q <= rx_s ^ (^sh) ^ (PARITY_ODD != 0);
          state <= STOP;
        end
        STOP: if (baud_tick) begin
          ferr_q <= ~rx_s;
          commit <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A held, unaccepted frame wins over a newly completed one
      if (commit && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (commit) begin
        rx_data <= sh;
        parity_err <= perr_q;
        frame_err <= ferr_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule
